ecg_frame_sequencer: RTL and testbench
======================================

# ecg_frame_sequencer

Frame-level controller that sequences the ECG CNN core (`ECG_Top`) over a continuous sample stream. It buffers one frame of `FRAME_LEN` samples and pulses the core's start. It then feeds samples whenever the core is in an input-consuming state and captures `detection_out` on `done`. Finally it pulses the core reset before accepting the next frame. It sits between the ADC/sample front end and the core, replacing the per-pattern stimulus loop with synthesizable control.

## Interface
- `N`, 16: sample and weight width.
- `FRAME_LEN`, 66: samples per frame.
- `RST_CYCLES`, 2: core-reset pulse length, in cycles.
- `TIMEOUT_CYCLES`, 4096: watchdog limit. Used only with `ECG_SEQ_TIMEOUT_EN`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: input sample valid.
- `s_ready` out 1: sequencer accepts a sample.
- `s_data` in N (signed): input sample.
- `cfg_win` in N (signed): weight, latched at frame start.
- `core_start` out 1: start pulse to the core.
- `core_rst` out 1: reset to the core.
- `core_xin` out N (signed): sample to the core.
- `core_win` out N (signed): latched weight to the core.
- `core_state` in 4: core FSM state.
- `core_done` in 1: core finished.
- `core_out` in N (signed): core `detection_out`.
- `res_valid` out 1: result available.
- `res_ready` in 1: result consumed.
- `res_data` out N (signed): captured detection result.
- `res_frame` out 8: frame index of the result.
- `res_err` out 1: result produced by timeout.
- `seq_state` out 3: sequencer state, for debug.

## Operation
- States and encodings: FILL=0, START=1, RUN=2, OUT=3, CRST=4.
- FILL
  - `s_ready`=1. Each `s_valid&&s_ready` writes `s_data` to `buf[wr_cnt]` and increments `wr_cnt`.
  - The handshake that writes index `FRAME_LEN-1` moves the FSM to START.
- START (one cycle)
  - `core_start`=1.
  - `cfg_win` is latched into `core_win`.
  - `rd_cnt` and the watchdog are cleared. Next state is RUN.
- RUN
  - Feed condition: `core_state` ∈ {1,3,4}.
  - `core_xin` is combinational: `buf[rd_cnt]` when the feed condition holds and `rd_cnt`<`FRAME_LEN`, else 0.
  - `rd_cnt` increments on each feed cycle and saturates at `FRAME_LEN`. Frame exhaustion therefore feeds zeros.
  - `core_done`=1: capture `core_out` into `res_data`, set `res_err`=0, then go to OUT.
- OUT
  - `res_valid`=1, holding `res_data`/`res_frame`/`res_err` stable until `res_ready`.
  - On the handshake, `frame_id` increments (8-bit, wraps 255→0) and the FSM goes to CRST.
- CRST
  - `core_rst`=1 for exactly `RST_CYCLES` cycles.
  - Then: clear `wr_cnt`, go to FILL.
- `core_rst` = `rst` OR (state==CRST), so the core is reset together with the sequencer.
- `s_data` presented outside FILL is ignored (not dropped silently upstream, since `s_ready`=0).
- `core_done` outside RUN is ignored.
- Simultaneous feed and `core_done` in RUN: the `rd_cnt` increment still occurs, and the capture takes priority for the state transition.
- Counter widths are `$clog2(FRAME_LEN+1)`. There is no arithmetic on samples; data passes through unmodified.

## Timing
- Reset values, in the cycle after `rst`:
  - state=FILL, so `s_ready`=1.
  - `core_start`=0, `core_xin`=0, `core_win`=0.
  - `res_valid`=0, `res_data`=0, `res_frame`=0, `res_err`=0.
  - `wr_cnt`=`rd_cnt`=`frame_id`=0.
  - `core_rst`=1 while `rst` is high.
- `rst` mid-frame (any state) discards the buffer and any pending result, and returns the FSM to FILL.
- Latency, last sample accepted → `core_start`: 1 cycle.
- `core_done` → `res_valid`: 1 cycle (registered).
- `res_ready` handshake → `core_rst` high: next cycle.
- Last `core_rst` cycle → `s_ready`: next cycle.
- `core_xin` is valid within the same cycle in which `core_state` indicates a feed state; the core samples it at the rising edge.

## Configuration
- `ECG_SEQ_TIMEOUT_EN` defined:
  - A watchdog counts RUN cycles.
  - On reaching `TIMEOUT_CYCLES` without `core_done`, the sequencer sets `res_data`=0 and `res_err`=1, then goes to OUT.
  - Normal CRST recovery follows.
- Undefined: no counter is built, `res_err` is tied to 0, and RUN waits indefinitely for `core_done`.

## Structure
- Shared package `ecg_pkg` holds:
  - The sequencer state typedef and encodings.
  - The core feed-state constants (1, 3, 4).
  - Default `N`/`FRAME_LEN`.
- Sub-module `ecg_frame_buf`: `FRAME_LEN`×`N` memory with synchronous write and asynchronous read. All control logic stays in `ecg_frame_sequencer`.

## Test plan
- Ramp frame 0,10,…,650 with `cfg_win`=2:
  - `core_start` pulses 1 cycle after the 66th handshake.
  - `core_xin` follows the ramp on feed states only.
  - `res_data` equals the `ECG_Top` golden value, with `res_frame`=0.
- Three back-to-back frames (ramp, descending 660−10i, sine 100·sin(i·π/16)):
  - Three results in order, `res_frame` 0,1,2.
  - `core_rst` high exactly 2 cycles between frames.
- `s_valid` toggling every other cycle during FILL and held during RUN: no sample loss, and `s_ready`=0 outside FILL.
- `res_ready` held low for 20 cycles: `res_valid` and `res_data` stay stable, and no `core_start` occurs.
- `rst` asserted in RUN after 30 fed samples:
  - Next cycle: FILL, `s_ready`=1, `res_valid`=0.
  - A new frame is then processed correctly.
- With `ECG_SEQ_TIMEOUT_EN`, `TIMEOUT_CYCLES`=64, and a core stub that never asserts `core_done`: `res_valid` with `res_err`=1 and `res_data`=0 after 64 RUN cycles.

Source files
------------

// File: rtl/ecg_pkg.sv
// ecg_pkg: definitions shared by the ECG frame sequencer slice.
//   - seq_state_t  : sequencer FSM state type and its fixed encodings
//   - CORE_ST_*    : ECG_Top FSM states in which the core consumes x_in
//   - ECG_N / ECG_FRAME_LEN : default sample width and frame length
//   - is_feed_state(): true when the core state consumes a sample
package ecg_pkg;

    localparam int ECG_N         = 16;
    localparam int ECG_FRAME_LEN = 66;

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_START = 3'd1,
        ST_RUN   = 3'd2,
        ST_OUT   = 3'd3,
        ST_CRST  = 3'd4
    } seq_state_t;

    // Core states that read core_xin on the next rising edge.
    localparam logic [3:0] CORE_ST_FEED_A = 4'd1;
    localparam logic [3:0] CORE_ST_FEED_B = 4'd3;
    localparam logic [3:0] CORE_ST_FEED_C = 4'd4;

    function automatic logic is_feed_state(input logic [3:0] st);
        return (st == CORE_ST_FEED_A) || (st == CORE_ST_FEED_B) ||
               (st == CORE_ST_FEED_C);
    endfunction

endpackage

// File: rtl/ecg_frame_sequencer_if.sv
// ecg_frame_sequencer_if: sample-in and result-out handshakes of the
// ECG frame sequencer.
//   s_valid/s_ready/s_data             : sample stream into the sequencer
//   res_valid/res_ready/res_data/
//   res_frame/res_err                  : detection result out of the sequencer
// Modports: slave = the sequencer, master = the front end / result sink.
interface ecg_frame_sequencer_if #(
    parameter int N = 16
);
    logic                s_valid;
    logic                s_ready;
    logic signed [N-1:0] s_data;

    logic                res_valid;
    logic                res_ready;
    logic signed [N-1:0] res_data;
    logic [7:0]          res_frame;
    logic                res_err;

    modport slave (
        input  s_valid, s_data, res_ready,
        output s_ready, res_valid, res_data, res_frame, res_err
    );

    modport master (
        output s_valid, s_data, res_ready,
        input  s_ready, res_valid, res_data, res_frame, res_err
    );
endinterface

// File: rtl/ecg_frame_buf.sv
// ecg_frame_buf: one-frame sample store, FRAME_LEN x N.
//   clk   : write clock
//   we    : write enable, waddr/wdata written on the rising edge
//   raddr : asynchronous read address, rdata follows combinationally
// Holds data only, so it carries no reset.
module ecg_frame_buf
    import ecg_pkg::*;
#(
    parameter int N         = ECG_N,
    parameter int FRAME_LEN = ECG_FRAME_LEN,
    parameter int AW        = $clog2(ECG_FRAME_LEN)
) (
    input  logic                clk,
    input  logic                we,
    input  logic [AW-1:0]       waddr,
    input  logic signed [N-1:0] wdata,
    input  logic [AW-1:0]       raddr,
    output logic signed [N-1:0] rdata
);

    logic signed [N-1:0] mem [FRAME_LEN];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ecg_frame_sequencer.sv
// ecg_frame_sequencer: sequences the ECG CNN core over a sample stream.
// Buffers one frame, pulses core_start, feeds samples while the core is in
// an input-consuming state, captures detection_out on core_done, hands the
// result out, then holds the core in reset for RST_CYCLES before refilling.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   sif (slave)     : s_valid/s_ready/s_data sample input,
//                     res_valid/res_ready/res_data/res_frame/res_err result
//   cfg_win         : weight, latched into core_win at frame start
//   core_start      : one-cycle start pulse to the core
//   core_rst        : core reset (rst OR post-frame reset window)
//   core_xin        : sample to the core, zero outside feed states
//   core_win        : latched weight to the core
//   core_state      : core FSM state
//   core_done       : core finished
//   core_out        : core detection_out
//   seq_state       : sequencer state, debug only
//
// Build option: define ECG_SEQ_TIMEOUT_EN to add a RUN watchdog that
// terminates a frame after TIMEOUT_CYCLES with res_err=1 and res_data=0.
module ecg_frame_sequencer
    import ecg_pkg::*;
#(
    parameter int N              = ECG_N,
    parameter int FRAME_LEN      = ECG_FRAME_LEN,
    parameter int RST_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    ecg_frame_sequencer_if.slave  sif,
    input  logic signed [N-1:0]   cfg_win,
    output logic                  core_start,
    output logic                  core_rst,
    output logic signed [N-1:0]   core_xin,
    output logic signed [N-1:0]   core_win,
    input  logic [3:0]            core_state,
    input  logic                  core_done,
    input  logic signed [N-1:0]   core_out,
    output logic [2:0]            seq_state
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int AW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES + 1) : 1;

    localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_LEN - 1);
    localparam logic [CW-1:0] FRAME_END = CW'(FRAME_LEN);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_CYCLES - 1);

    seq_state_t          state;
    logic [CW-1:0]       wr_cnt;
    logic [CW-1:0]       rd_cnt;
    logic [RW-1:0]       crst_cnt;
    logic [7:0]          frame_id;
    logic signed [N-1:0] res_data_r;
    logic signed [N-1:0] buf_rdata;
    logic                s_fire;
    logic                feed;

`ifdef ECG_SEQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

    logic [WW-1:0] wdog;
    logic          res_err_r;

    assign sif.res_err = res_err_r;
`else
    // Watchdog not built; the parameter is kept for a uniform interface.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign sif.res_err        = 1'b0;
`endif

    assign s_fire = sif.s_valid && (state == ST_FILL);
    assign feed   = (state == ST_RUN) && is_feed_state(core_state);

    assign sif.s_ready   = (state == ST_FILL);
    assign sif.res_valid = (state == ST_OUT);
    assign sif.res_data  = res_data_r;
    assign sif.res_frame = frame_id;
    assign seq_state     = state;

    // Reset the core together with the sequencer, not one cycle later.
    assign core_rst = rst || (state == ST_CRST);

    // Once the frame is exhausted rd_cnt parks at FRAME_LEN and the core
    // is fed zeros for any further input states.
    assign core_xin = (feed && (rd_cnt < FRAME_END)) ? buf_rdata : '0;

    ecg_frame_buf #(
        .N         (N),
        .FRAME_LEN (FRAME_LEN),
        .AW        (AW)
    ) u_buf (
        .clk   (clk),
        .we    (s_fire),
        .waddr (wr_cnt[AW-1:0]),
        .wdata (sif.s_data),
        .raddr (rd_cnt[AW-1:0]),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_FILL;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            crst_cnt   <= '0;
            frame_id   <= '0;
            core_start <= 1'b0;
            core_win   <= '0;
            res_data_r <= '0;
`ifdef ECG_SEQ_TIMEOUT_EN
            wdog       <= '0;
            res_err_r  <= 1'b0;
`endif
        end else begin
            core_start <= 1'b0;
            unique case (state)
                ST_FILL: begin
                    if (s_fire) begin
                        wr_cnt <= wr_cnt + CW'(1);
                        if (wr_cnt == LAST_IDX) begin
                            state      <= ST_START;
                            core_start <= 1'b1;
                        end
                    end
                end

                ST_START: begin
                    core_win <= cfg_win;
                    rd_cnt   <= '0;
`ifdef ECG_SEQ_TIMEOUT_EN
                    wdog     <= '0;
`endif
                    state    <= ST_RUN;
                end

                ST_RUN: begin
                    // A feed in the same cycle as core_done still advances.
                    if (feed && (rd_cnt != FRAME_END)) begin
                        rd_cnt <= rd_cnt + CW'(1);
                    end
                    if (core_done) begin
                        res_data_r <= core_out;
`ifdef ECG_SEQ_TIMEOUT_EN
                        res_err_r  <= 1'b0;
`endif
                        state      <= ST_OUT;
                    end
`ifdef ECG_SEQ_TIMEOUT_EN
                    else if (wdog == WD_LAST) begin
                        res_data_r <= '0;
                        res_err_r  <= 1'b1;
                        state      <= ST_OUT;
                    end else begin
                        wdog <= wdog + WW'(1);
                    end
`endif
                end

                ST_OUT: begin
                    if (sif.res_ready) begin
                        frame_id <= frame_id + 8'd1;
                        crst_cnt <= '0;
                        state    <= ST_CRST;
                    end
                end

                ST_CRST: begin
                    if (crst_cnt == RST_LAST) begin
                        wr_cnt <= '0;
                        state  <= ST_FILL;
                    end else begin
                        crst_cnt <= crst_cnt + RW'(1);
                    end
                end

                default: state <= ST_FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_ecg_frame_sequencer.sv
module tb_ecg_frame_sequencer;

    localparam int FRAME_LEN = 66;
    localparam int RST_CYC   = 2;
    localparam int TMO       = 64;

    typedef struct {
        logic signed [15:0] data;
        logic [7:0]         frame;
        logic               err;
    } exp_t;

    logic               clk;
    logic               rst;
    logic signed [15:0] cfg_win;
    logic               core_start;
    logic               core_rst;
    logic signed [15:0] core_xin;
    logic signed [15:0] core_win;
    logic [3:0]         core_state;
    logic               core_done;
    logic               stub_done;
    logic               tb_done;
    logic signed [15:0] core_out;
    logic [2:0]         seq_state;

    ecg_frame_sequencer_if #(.N(16)) ifc ();

    ecg_frame_sequencer #(
        .N              (16),
        .FRAME_LEN      (FRAME_LEN),
        .RST_CYCLES     (RST_CYC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sif        (ifc),
        .cfg_win    (cfg_win),
        .core_start (core_start),
        .core_rst   (core_rst),
        .core_xin   (core_xin),
        .core_win   (core_win),
        .core_state (core_state),
        .core_done  (core_done),
        .core_out   (core_out),
        .seq_state  (seq_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    endtask

    exp_t               sb[$];
    logic signed [15:0] cur_frame [FRAME_LEN];
    logic [7:0]         tb_frame = 8'd0;
    int                 xin_idx  = 0;
    int                 crst_run = 0;

    // Core stand-in: walks a mix of feed (1,3,4) and non-feed (2,5) states,
    // accumulates x_in*w_in over FRAME_LEN+2 feeds, then pulses done.
    bit  stub_busy;
    bit  stub_hang = 1'b0;
    int  st_j, nfeed, acc;
    int  stub_prod;
    logic stub_feed;

    assign stub_prod = int'(core_xin) * int'(core_win);
    assign stub_feed = (core_state == 4'd1) || (core_state == 4'd3) || (core_state == 4'd4);
    assign core_done = stub_done | tb_done;

    function automatic logic [3:0] pat_st(input int j);
        case (j % 6)
            0, 1:    return 4'd1;
            2:       return 4'd2;
            3:       return 4'd3;
            4:       return 4'd4;
            default: return 4'd5;
        endcase
    endfunction

    function automatic logic signed [15:0] lo16(input int v);
        return v[15:0];
    endfunction

    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (core_rst) begin
            stub_busy  <= 1'b0;
            core_state <= 4'd0;
            acc        <= 0;
            nfeed      <= 0;
            st_j       <= 0;
            core_out   <= '0;
        end else if (core_start) begin
            stub_busy  <= 1'b1;
            core_state <= 4'd1;
            st_j       <= 1;
            acc        <= 0;
            nfeed      <= 0;
        end else if (stub_busy) begin
            if (stub_feed) begin
                acc   <= acc + stub_prod;
                nfeed <= nfeed + 1;
            end
            if (!stub_hang && stub_feed && (nfeed + 1 >= FRAME_LEN + 2)) begin
                stub_busy  <= 1'b0;
                core_state <= 4'd6;
                stub_done  <= 1'b1;
                core_out   <= lo16(acc + stub_prod);
            end else begin
                core_state <= pat_st(st_j);
                st_j       <= st_j + 1;
            end
        end
    end

    // Feed-path monitor: in feed states core_xin must walk the frame, then zeros.
    always @(negedge clk) begin
        if (!rst) begin
            if (core_start) xin_idx = 0;
            if (stub_feed && seq_state == 3'd2) begin
                chk("core_xin", core_xin, (xin_idx < FRAME_LEN) ? cur_frame[xin_idx] : 16'sd0);
                xin_idx++;
            end else begin
                chk("core_xin_idle", core_xin, 0);
            end
        end
    end

    // Core-reset window length between frames.
    always @(negedge clk) begin
        if (rst) crst_run = 0;
        else if (core_rst) crst_run++;
        else if (crst_run > 0) begin
            chk("crst_len", crst_run, RST_CYC);
            crst_run = 0;
        end
    end

    // Scoreboard: compare on each result handshake.
    always @(negedge clk) begin
        if (!rst && ifc.res_valid && ifc.res_ready) begin
            if (sb.size() == 0) chk("sb_unexpected", ifc.res_frame, -1);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("res_data", ifc.res_data, e.data);
                chk("res_frame", ifc.res_frame, e.frame);
                chk("res_err", ifc.res_err, e.err);
            end
        end
    end

    // kind: 0 = no result expected, 1 = normal result, 2 = timeout result
    task automatic send_frame(input bit alt, input logic signed [15:0] win, input int kind);
        int   i, guard, sum;
        bit   tog, hs;
        exp_t e;
        i = 0; guard = 0; tog = 1'b1;
        cfg_win = win;
        while (i < FRAME_LEN && guard < 600) begin
            ifc.s_valid = alt ? tog : 1'b1;
            ifc.s_data  = cur_frame[i];
            tog = !tog;
            hs  = ifc.s_valid && ifc.s_ready;
            @(posedge clk); #1;
            if (hs) i++;
            guard++;
        end
        chk("fill_cnt", i, FRAME_LEN);
        chk("start_lat", core_start, 1);
        chk("s_ready_start", ifc.s_ready, 0);
        if (alt) ifc.s_data = 16'sh1234;
        else ifc.s_valid = 1'b0;
        sum = 0;
        for (int k = 0; k < FRAME_LEN; k++) sum += int'(cur_frame[k]) * int'(win);
        if (kind != 0) begin
            e.data  = (kind == 2) ? 16'sd0 : lo16(sum);
            e.frame = tb_frame;
            e.err   = (kind == 2);
            sb.push_back(e);
            tb_frame = tb_frame + 8'd1;
        end
        @(posedge clk); #1;
        chk("core_win", core_win, win);
        chk("start_pulse", core_start, 0);
        cfg_win = 16'(($urandom % 30000) + 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || !ifc.s_ready) && n < 3000) begin
            if (ifc.res_valid && ifc.s_valid) begin
                chk("s_ready_run", ifc.s_ready, 0);
                ifc.s_valid = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        if (n >= 3000) chk(tag, sb.size(), 0);
    endtask

    initial begin
        rst = 1'b1; cfg_win = '0; tb_done = 1'b0;
        ifc.s_valid = 1'b0; ifc.s_data = '0; ifc.res_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_seq_state", seq_state, 0);
        chk("rst_s_ready", ifc.s_ready, 1);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_xin", core_xin, 0);
        chk("rst_core_win", core_win, 0);
        chk("rst_res_valid", ifc.res_valid, 0);
        chk("rst_res_data", ifc.res_data, 0);
        chk("rst_res_frame", ifc.res_frame, 0);
        chk("rst_res_err", ifc.res_err, 0);
        chk("rst_core_rst", core_rst, 1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("core_rst_rel", core_rst, 0);

        // core_done while filling must be ignored
        tb_done = 1'b1;
        @(posedge clk); #1;
        tb_done = 1'b0;
        chk("done_in_fill_valid", ifc.res_valid, 0);
        chk("done_in_fill_state", seq_state, 0);

        // back-to-back: ramp, descending, sine
        for (int i = 0; i < FRAME_LEN; i++) cur_frame[i] = 16'(10 * i);
        send_frame(1'b0, 16'sd2, 1);
        wait_idle("idle_ramp");
        for (int i = 0; i < FRAME_LEN; i++) cur_frame[i] = 16'(660 - 10 * i);
        send_frame(1'b0, 16'sd3, 1);
        wait_idle("idle_desc");
        for (int i = 0; i < FRAME_LEN; i++)
            cur_frame[i] = 16'($rtoi(100.0 * $sin(i * 3.14159265358979 / 16.0)));
        send_frame(1'b0, -16'sd1, 1);
        wait_idle("idle_sine");

        // s_valid toggling during fill, held high through run
        for (int i = 0; i < FRAME_LEN; i++) cur_frame[i] = 16'($urandom_range(0, 4000)) - 16'sd2000;
        send_frame(1'b1, 16'sd5, 1);
        wait_idle("idle_alt");

        // result held with res_ready low for 20 cycles
        ifc.res_ready = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) cur_frame[i] = 16'(i * i);
        send_frame(1'b0, -16'sd3, 1);
        begin
            int n;
            n = 0;
            while (!ifc.res_valid && n < 500) begin
                @(posedge clk); #1; n++;
            end
            chk("hold_reach", ifc.res_valid, 1);
        end
        for (int c = 0; c < 20; c++) begin
            chk("hold_valid", ifc.res_valid, 1);
            if (sb.size() > 0) begin
                chk("hold_data", ifc.res_data, sb[0].data);
                chk("hold_frame", ifc.res_frame, sb[0].frame);
            end
            chk("hold_no_start", core_start, 0);
            @(posedge clk); #1;
        end
        ifc.res_ready = 1'b1;
        wait_idle("idle_hold");

        // reset in RUN after 30 fed samples
        for (int i = 0; i < FRAME_LEN; i++) cur_frame[i] = 16'(7 * i - 100);
        send_frame(1'b0, 16'sd4, 0);
        begin
            int n;
            n = 0;
            while (xin_idx < 30 && n < 300) begin
                @(posedge clk); #1; n++;
            end
            chk("fed_30", (xin_idx >= 30), 1);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_state", seq_state, 0);
        chk("mid_rst_s_ready", ifc.s_ready, 1);
        chk("mid_rst_res_valid", ifc.res_valid, 0);
        chk("mid_rst_core_rst", core_rst, 1);
        rst = 1'b0;
        tb_frame = 8'd0;
        for (int i = 0; i < FRAME_LEN; i++) cur_frame[i] = 16'(300 - 9 * i);
        send_frame(1'b0, 16'sd6, 1);
        wait_idle("idle_after_rst");

`ifdef ECG_SEQ_TIMEOUT_EN
        stub_hang = 1'b1;
        for (int i = 0; i < FRAME_LEN; i++) cur_frame[i] = 16'(i);
        send_frame(1'b0, 16'sd1, 2);
        begin
            int n;
            n = 0;
            while (!ifc.res_valid && n < 500) begin
                @(posedge clk); #1; n++;
            end
            chk("wdog_cycles", n, TMO);
        end
        wait_idle("idle_timeout");
        stub_hang = 1'b0;
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
